ifetch_queue: RTL and testbench

Instruction fetch front-end that generates sequential PCs, issues requests to instruction memory, and buffers returned words in a small in-order queue for the decode stage. It sits directly upstream of decode and replaces the bare PC register + combinational imem hookup. Execute-stage jumps and taken branches redirect it, which flushes all buffered and in-flight fetches. Decode back-pressures it through a ready signal, which is the load-use stall.

---
 rtl/ifetch_queue_pkg.sv | 16 +
 rtl/ifetch_queue_if.sv | 27 ++
 rtl/ifetch_queue_sync_fifo.sv | 60 ++++++
 rtl/ifetch_queue.sv | 98 +++++++++
 tb/tb_ifetch_queue.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared fetch pipeline definitions: data width, reset PC default and the queued entry layout.
package ifetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus: redirect from execute, instruction memory request/response, decode handshake.
interface ifetch_queue_if;
    import ifetch_queue_pkg::*;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            dec_valid;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_inst;
    logic            dec_ready;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, dec_valid, dec_pc, dec_inst
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, dec_valid, dec_pc, dec_inst
    );

endinterface

// File: rtl/ifetch_queue_sync_fifo.sv
// Synchronous in-order FIFO with flush; head output reads as zero whenever the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: sequential PC generation, credit-limited imem requests,
// in-order response queue toward decode, and redirect flush with in-flight response dropping.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    ifetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            fifo_full;
    logic            fifo_empty;
    logic            credit_ok;
    logic            fire;
    logic            keep;
    logic            pop;
    logic [XLEN-1:0] target;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Credit counts queued plus in-flight words against the registered count only,
    // so a pop this cycle never frees a slot until the next one.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign credit_ok = (in_use < (CW+1)'(DEPTH));

    assign bus.imem_req  = !reset && !bus.redirect && credit_ok;
    assign bus.imem_addr = fetch_pc;

    assign fire   = bus.imem_req && bus.imem_gnt;
    assign keep   = bus.imem_rvalid && (drop == '0) && !bus.redirect;
    assign pop    = !fifo_empty && bus.dec_ready && !bus.redirect;
    assign target = word_align(bus.redirect_pc);

    assign push_entry = '{pc: resp_pc, inst: bus.imem_rdata};

    assign bus.dec_valid = !fifo_empty;
    assign bus.dec_pc    = head_entry.pc;
    assign bus.dec_inst  = head_entry.inst;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(bus.imem_rvalid);
            if (bus.redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= target;
                resp_pc  <= target;
                drop     <= outstanding - CW'(bus.imem_rvalid);
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (bus.imem_rvalid) begin
                    if (drop != '0) begin
                        drop <= drop - CW'(1);
                    end else begin
                        resp_pc <= resp_pc + 32'd4;
                    end
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (keep),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(keep && fifo_full))
        else $fatal(1, "ifetch_queue: push into full queue");

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed phases push expected fetch addresses and decoded
// {pc, inst} pairs; a monitor pops and compares on every grant and every accepted decode.
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ifetch_queue_if bus ();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0100_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int bad    = 0;
    int issued = 0;
    int limit  = 0;
    int lat    = 1;
    int cyc    = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_dec[$];
    logic [31:0] mon_e;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Memory: grants only while under the phase's grant limit, answers in order after lat cycles.
    assign bus.imem_gnt = bus.imem_req && (issued < limit);

    always @(posedge clock) begin
        if (reset) begin
            pend.delete();
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= '0;
        end else begin
            if (bus.imem_req && bus.imem_gnt) begin
                pend.push_back('{bus.imem_addr, cyc + lat - 1});
                issued <= issued + 1;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= inst_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.imem_rvalid <= 1'b0;
                bus.imem_rdata  <= '0;
            end
        end
        cyc++;
    end

    always begin
        @(negedge clock);
        #1;
        if (!reset) begin
            if (bus.imem_req && bus.imem_gnt) begin
                if (exp_addr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got addr %h want none", bus.imem_addr);
                end else begin
                    check("imem_addr", bus.imem_addr, exp_addr.pop_front());
                end
            end
            if (bus.dec_valid && bus.dec_ready && !bus.redirect) begin
                if (exp_dec.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dec: got pc %h want none", bus.dec_pc);
                end else begin
                    mon_e = exp_dec.pop_front();
                    check("dec_pc", bus.dec_pc, mon_e);
                    check("dec_inst", bus.dec_inst, inst_of(mon_e));
                end
            end
        end
    end

    task automatic push_both(input logic [31:0] pc);
        exp_addr.push_back(pc);
        exp_dec.push_back(pc);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_dec.size() != 0) && n < 200) begin
            @(negedge clock);
            #2;
            n++;
        end
        total++;
        if (exp_addr.size() != 0 || exp_dec.size() != 0) begin
            bad++;
            $display("FAIL drain_%s: got %0d addr/%0d dec pending want 0/0",
                     name, exp_addr.size(), exp_dec.size());
            exp_addr.delete();
            exp_dec.delete();
        end
        @(negedge clock);
    endtask

    // Called at a drive point; returns 2 units after the following falling edge.
    task automatic do_redirect(input logic [31:0] pc, input logic [31:0] want);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        #2;
        check("redir_req_low", 32'(bus.imem_req), 32'd0);
        @(negedge clock);
        bus.redirect = 1'b0;
        #2;
        check("redir_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("redir_req", 32'(bus.imem_req), 32'd1);
        check("redir_addr", bus.imem_addr, want);
    endtask

    initial begin
        int n;
        int base;
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready   = 1'b0;
        reset           = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("rst_dec_pc", bus.dec_pc, 32'd0);
        check("rst_dec_inst", bus.dec_inst, 32'd0);

        // Streaming from reset, L=1, decode always ready.
        @(negedge clock);
        lat           = 1;
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_both(32'h0100_0000 + 32'(4 * i));
        limit = issued + 8;
        reset = 1'b0;
        #2;
        check("boot_req", 32'(bus.imem_req), 32'd1);
        check("boot_addr", bus.imem_addr, 32'h0100_0000);
        @(negedge clock);
        #2;
        check("boot_valid_c1", 32'(bus.dec_valid), 32'd0);
        @(negedge clock);
        #2;
        check("boot_valid_c2", 32'(bus.dec_valid), 32'd1);
        n = 1;
        while (exp_dec.size() > 0 && n < 40) begin
            @(negedge clock);
            #2;
            n++;
        end
        check("stream_cycles", 32'(n), 32'd8);
        wait_drain("boot");

        // Decode stall: fetch fills exactly DEPTH then stops; release drains back-to-back.
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h0100_0020 + 32'(4 * i));
        base  = issued;
        limit = issued + 100;
        repeat (10) @(negedge clock);
        #2;
        check("stall_grants", 32'(issued - base), 32'd4);
        check("stall_req", 32'(bus.imem_req), 32'd0);
        check("stall_valid", 32'(bus.dec_valid), 32'd1);
        check("stall_head", bus.dec_pc, 32'h0100_0020);
        @(negedge clock);
        limit = issued;
        for (int i = 0; i < 4; i++) exp_dec.push_back(32'h0100_0020 + 32'(4 * i));
        bus.dec_ready = 1'b1;
        n = 0;
        do begin
            #2;
            n++;
            if (exp_dec.size() == 0) break;
            @(negedge clock);
        end while (n < 40);
        check("drain_cycles", 32'(n), 32'd4);
        wait_drain("stall");

        // Redirect with three requests in flight (L=4): all three responses discarded.
        lat = 4;
        for (int i = 0; i < 3; i++) exp_addr.push_back(32'h0100_0030 + 32'(4 * i));
        base  = issued;
        limit = issued + 3;
        n = 0;
        while (issued < base + 3 && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("inflight_grants", 32'(issued - base), 32'd3);
        push_both(32'h0100_0100);
        push_both(32'h0100_0104);
        limit = issued + 2;
        do_redirect(32'h0100_0100, 32'h0100_0100);
        wait_drain("inflight");

        // Redirect in the same cycle as a response and a pop.
        lat           = 1;
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) exp_addr.push_back(32'h0100_0108 + 32'(4 * i));
        limit = issued + 3;
        repeat (6) @(negedge clock);
        #2;
        check("corner_head", bus.dec_pc, 32'h0100_0108);
        @(negedge clock);
        exp_addr.push_back(32'h0100_0114);
        limit = issued + 1;
        @(negedge clock);
        push_both(32'h0200_0000);
        push_both(32'h0200_0004);
        limit = issued + 2;
        bus.dec_ready = 1'b1;
        do_redirect(32'h0200_0000, 32'h0200_0000);
        wait_drain("corner");

        // Target alignment, PC wrap and back-to-back redirects.
        push_both(32'h0100_0100);
        limit = issued + 1;
        do_redirect(32'h0100_0102, 32'h0100_0100);
        wait_drain("align");
        push_both(32'hFFFF_FFFC);
        push_both(32'h0000_0000);
        limit = issued + 2;
        do_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        wait_drain("wrap");
        push_both(32'h0400_0000);
        limit = issued + 1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0300_0000;
        @(negedge clock);
        do_redirect(32'h0400_0000, 32'h0400_0000);
        wait_drain("b2b");

        // Reset with a full queue, then refetch from the reset PC.
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h0500_0000 + 32'(4 * i));
        limit = issued + 4;
        do_redirect(32'h0500_0000, 32'h0500_0000);
        repeat (8) @(negedge clock);
        #2;
        check("full_valid", 32'(bus.dec_valid), 32'd1);
        check("full_req", 32'(bus.imem_req), 32'd0);
        check("full_head", bus.dec_pc, 32'h0500_0000);
        check("full_addrs_left", 32'(exp_addr.size()), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #2;
        check("mid_rst_req", 32'(bus.imem_req), 32'd0);
        check("mid_rst_valid", 32'(bus.dec_valid), 32'd0);
        check("mid_rst_pc", bus.dec_pc, 32'd0);
        check("mid_rst_inst", bus.dec_inst, 32'd0);
        @(negedge clock);
        reset         = 1'b0;
        bus.dec_ready = 1'b1;
        push_both(32'h0100_0000);
        push_both(32'h0100_0004);
        limit = issued + 2;
        #2;
        check("refetch_addr", bus.imem_addr, 32'h0100_0000);
        wait_drain("refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
